// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module mdu_div_step #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quot,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] next_rem,
    output logic [W-1:0] next_quot
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // rem < divisor always holds, so a clear borrow bit means the difference fits W bits
    always_comb begin
        shifted   = {rem, quot[W-1]};
        diff      = shifted - {1'b0, divisor};
        next_rem  = diff[W] ? shifted[W-1:0] : diff[W-1:0];
        next_quot = {quot[W-2:0], ~diff[W]};
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit with valid/ready request and one-cycle result pulse.
// Optional MDU_FAST_MUL_EN: single-cycle multiplies, divide path unchanged.
module mdu_iter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      mdu_op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);
    import mdu_pkg::*;

    mdu_state_e        state;
    mdu_op_e           op_q;
    mdu_op_e           op_in;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   opnd_q;
    logic              neg_q;
    logic              special_q;
    logic [XLEN-1:0]   special_res_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   div_rem, div_quot;
    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   quot_c, rem_c;
    logic [XLEN-1:0]   final_res;

    assign op_in = mdu_op_e'(mdu_op_i);

    always_comb begin
        a_signed    = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed    = op_in inside {OP_MULH, OP_DIV, OP_REM};
        a_neg       = a_signed & operand_a_i[XLEN-1];
        b_neg       = b_signed & operand_b_i[XLEN-1];
        mag_a       = a_neg ? -operand_a_i : operand_a_i;
        mag_b       = b_neg ? -operand_b_i : operand_b_i;
        // remainder follows the dividend; quotient and product follow the sign xor
        neg_in      = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
        div_zero    = op_in[2] && (operand_b_i == '0);
        div_ovf     = (op_in inside {OP_DIV, OP_REM}) &&
                      (operand_a_i == INT_MIN) && (operand_b_i == '1);
        if (div_zero)
            special_res = op_in[1] ? operand_a_i : DIV0_QUOT;
        else
            special_res = op_in[1] ? '0 : INT_MIN;
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    assign fast_a    = {{XLEN{a_neg}}, operand_a_i};
    assign fast_b    = {{XLEN{b_neg}}, operand_b_i};
    assign fast_prod = fast_a * fast_b;
`endif

    // hi_q:lo_q is the product accumulator (multiplier shifts out of lo_q),
    // or remainder:quotient while dividing (dividend shifts out of lo_q)
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

    mdu_div_step #(.W(XLEN)) u_div_step (
        .rem       (hi_q),
        .quot      (lo_q),
        .divisor   (opnd_q),
        .next_rem  (div_rem),
        .next_quot (div_quot)
    );

    always_comb begin
        prod_c = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quot_c = neg_q ? -lo_q : lo_q;
        rem_c  = neg_q ? -hi_q : hi_q;
        if (special_q) begin
            final_res = special_res_q;
        end else begin
            unique case (op_q)
                OP_MUL:                        final_res = prod_c[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_c[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU:               final_res = quot_c;
                default:                       final_res = rem_c;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            ready_o       <= 1'b1;
            busy_o        <= 1'b0;
            valid_o       <= 1'b0;
            result_o      <= '0;
            cnt_q         <= '0;
            op_q          <= OP_MUL;
            hi_q          <= '0;
            lo_q          <= '0;
            opnd_q        <= '0;
            neg_q         <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
        end else begin
            valid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    // ready_o is still low during the result cycle; reopen afterwards
                    if (!ready_o || kill_i) begin
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                    end else if (valid_i) begin
                        ready_o       <= 1'b0;
                        busy_o        <= 1'b1;
                        op_q          <= op_in;
                        neg_q         <= neg_in;
                        cnt_q         <= '0;
                        hi_q          <= '0;
                        lo_q          <= op_in[2] ? mag_a : mag_b;
                        opnd_q        <= op_in[2] ? mag_b : mag_a;
                        special_res_q <= special_res;
                        if (div_zero || div_ovf) begin
                            special_q <= 1'b1;
                            state     <= DONE;
                        end else begin
                            special_q <= 1'b0;
`ifdef MDU_FAST_MUL_EN
                            if (!op_in[2]) begin
                                hi_q  <= fast_prod[2*XLEN-1:XLEN];
                                lo_q  <= fast_prod[XLEN-1:0];
                                neg_q <= 1'b0;
                                state <= DONE;
                            end else begin
                                state <= CALC;
                            end
`else
                            state     <= CALC;
`endif
                        end
                    end
                end
                CALC: begin
                    if (kill_i) begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                    end else begin
                        if (op_q[2]) begin
                            hi_q <= div_rem;
                            lo_q <= div_quot;
                        end else begin
                            hi_q <= mul_sum[XLEN:1];
                            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
                        end
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(XLEN - 1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (kill_i) begin
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                    end else begin
                        valid_o  <= 1'b1;
                        result_o <= final_res;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter; expected values are hand-computed constants.
module tb_mdu_iter;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  mdu_op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        kill_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mdu_iter #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .mdu_op_i    (mdu_op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .kill_i      (kill_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .result_o    (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for ready, presents one request for one edge, then waits (bounded) for valid_o.
    // Called and returns 1 time unit after a rising edge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res,
                          output logic busy_ok, output logic ready_ok);
        int guard;
        guard = 0;
        while (!ready_o && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        mdu_op_i = op; operand_a_i = a; operand_b_i = b; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i  = 1'b0;
        lat      = 0;
        res      = 32'hDEAD_BEEF;
        busy_ok  = 1'b1;
        ready_ok = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            if (!busy_o) busy_ok = 1'b0;
            if (ready_o) ready_ok = 1'b0;
            @(posedge clk); #1;
            if (valid_o) begin
                lat = n;
                res = result_o;
                if (!busy_o) busy_ok = 1'b0;
                if (ready_o) ready_ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; valid_i = 1'b0; kill_i = 1'b0;
        mdu_op_i = 3'b000; operand_a_i = '0; operand_b_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_ni = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else pass_cnt++;
        total_cnt++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_o); else pass_cnt++;
        total_cnt++; if (result_o !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result_o); else pass_cnt++;
    endtask

    task automatic test_mul_basic();
        int lat; logic [31:0] res; logic bok, rok;
        run_op(3'b000, 32'd10, 32'd5, lat, res, bok, rok);
        total_cnt++; if (res !== 32'h0000_0032) $display("FAIL mul_result: got %h expected 00000032", res); else pass_cnt++;
        total_cnt++; if (lat !== MUL_LAT) $display("FAIL mul_latency: got %0d expected %0d", lat, MUL_LAT); else pass_cnt++;
        total_cnt++; if (bok !== 1'b1) $display("FAIL mul_busy_held: got %b expected 1", bok); else pass_cnt++;
        total_cnt++; if (rok !== 1'b1) $display("FAIL mul_ready_low: got %b expected 1", rok); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (valid_o !== 1'b0) $display("FAIL mul_valid_pulse: got %b expected 0", valid_o); else pass_cnt++;
        total_cnt++; if (ready_o !== 1'b1) $display("FAIL mul_ready_after: got %b expected 1", ready_o); else pass_cnt++;
        total_cnt++; if (result_o !== 32'h0000_0032) $display("FAIL mul_result_hold: got %h expected 00000032", result_o); else pass_cnt++;
    endtask

    task automatic test_mul_high();
        int lat; logic [31:0] res; logic bok, rok;
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, bok, rok);
        total_cnt++; if (res !== 32'hFFFF_FFFE) $display("FAIL mulhu_result: got %h expected fffffffe", res); else pass_cnt++;
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, bok, rok);
        total_cnt++; if (res !== 32'h0000_0000) $display("FAIL mulh_result: got %h expected 00000000", res); else pass_cnt++;
        run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, lat, res, bok, rok);
        total_cnt++; if (res !== 32'hFFFF_FFFF) $display("FAIL mulhsu_result: got %h expected ffffffff", res); else pass_cnt++;
        total_cnt++; if (lat !== MUL_LAT) $display("FAIL mulhsu_latency: got %0d expected %0d", lat, MUL_LAT); else pass_cnt++;
    endtask

    task automatic test_div();
        int lat; logic [31:0] res; logic bok, rok;
        run_op(3'b100, 32'hFFFF_FFEC, 32'd3, lat, res, bok, rok);
        total_cnt++; if (res !== 32'hFFFF_FFFA) $display("FAIL div_result: got %h expected fffffffa", res); else pass_cnt++;
        total_cnt++; if (lat !== DIV_LAT) $display("FAIL div_latency: got %0d expected %0d", lat, DIV_LAT); else pass_cnt++;
        run_op(3'b110, 32'hFFFF_FFEC, 32'd3, lat, res, bok, rok);
        total_cnt++; if (res !== 32'hFFFF_FFFE) $display("FAIL rem_result: got %h expected fffffffe", res); else pass_cnt++;
        run_op(3'b101, 32'hFFFF_FFEC, 32'd3, lat, res, bok, rok);
        total_cnt++; if (res !== 32'h5555_554E) $display("FAIL divu_result: got %h expected 5555554e", res); else pass_cnt++;
        run_op(3'b111, 32'hFFFF_FFEC, 32'd3, lat, res, bok, rok);
        total_cnt++; if (res !== 32'h0000_0002) $display("FAIL remu_result: got %h expected 00000002", res); else pass_cnt++;
    endtask

    task automatic test_special();
        int lat; logic [31:0] res; logic bok, rok;
        run_op(3'b101, 32'd7, 32'd0, lat, res, bok, rok);
        total_cnt++; if (res !== 32'hFFFF_FFFF) $display("FAIL divu0_result: got %h expected ffffffff", res); else pass_cnt++;
        total_cnt++; if (lat !== 1) $display("FAIL divu0_latency: got %0d expected 1", lat); else pass_cnt++;
        run_op(3'b111, 32'd7, 32'd0, lat, res, bok, rok);
        total_cnt++; if (res !== 32'h0000_0007) $display("FAIL remu0_result: got %h expected 00000007", res); else pass_cnt++;
        total_cnt++; if (lat !== 1) $display("FAIL remu0_latency: got %0d expected 1", lat); else pass_cnt++;
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, bok, rok);
        total_cnt++; if (res !== 32'h8000_0000) $display("FAIL div_ovf_result: got %h expected 80000000", res); else pass_cnt++;
        total_cnt++; if (lat !== 1) $display("FAIL div_ovf_latency: got %0d expected 1", lat); else pass_cnt++;
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, bok, rok);
        total_cnt++; if (res !== 32'h0000_0000) $display("FAIL rem_ovf_result: got %h expected 00000000", res); else pass_cnt++;
    endtask

    task automatic test_kill();
        int lat; logic [31:0] res; logic bok, rok; logic seen;
        run_op(3'b101, 32'd100, 32'd7, lat, res, bok, rok);
        total_cnt++; if (res !== 32'h0000_000E) $display("FAIL kill_setup_result: got %h expected 0000000e", res); else pass_cnt++;
        @(posedge clk); #1;
        // kill in IDLE with a pending request must block acceptance
        mdu_op_i = 3'b100; operand_a_i = 32'd50; operand_b_i = 32'd5;
        valid_i = 1'b1; kill_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; kill_i = 1'b0;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL kill_idle_busy: got %b expected 0", busy_o); else pass_cnt++;
        // kill ten cycles into a DIV
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        total_cnt++; if (ready_o !== 1'b1) $display("FAIL kill_calc_ready: got %b expected 1", ready_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL kill_calc_busy: got %b expected 0", busy_o); else pass_cnt++;
        seen = valid_o;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_o) seen = 1'b1;
        end
        total_cnt++; if (seen !== 1'b0) $display("FAIL kill_calc_no_valid: got %b expected 0", seen); else pass_cnt++;
        total_cnt++; if (result_o !== 32'h0000_000E) $display("FAIL kill_calc_result_hold: got %h expected 0000000e", result_o); else pass_cnt++;
    endtask

    task automatic test_kill_done();
        logic seen;
        mdu_op_i = 3'b101; operand_a_i = 32'd50; operand_b_i = 32'd5; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        // 32 more edges leave the unit in its DONE cycle
        repeat (32) @(posedge clk);
        #1 kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        total_cnt++; if (valid_o !== 1'b0) $display("FAIL kill_done_valid: got %b expected 0", valid_o); else pass_cnt++;
        total_cnt++; if (ready_o !== 1'b1) $display("FAIL kill_done_ready: got %b expected 1", ready_o); else pass_cnt++;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (valid_o) seen = 1'b1;
        end
        total_cnt++; if (seen !== 1'b0) $display("FAIL kill_done_no_valid: got %b expected 0", seen); else pass_cnt++;
        total_cnt++; if (result_o !== 32'h0000_000E) $display("FAIL kill_done_result_hold: got %h expected 0000000e", result_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] res; logic bok, rok;
        mdu_op_i = 3'b000; operand_a_i = 32'h1234_5678; operand_b_i = 32'd3; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_ni = 1'b0;
        #1;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy_o); else pass_cnt++;
        total_cnt++; if (ready_o !== 1'b1) $display("FAIL rst_mid_ready: got %b expected 1", ready_o); else pass_cnt++;
        total_cnt++; if (result_o !== 32'h0) $display("FAIL rst_mid_result: got %h expected 00000000", result_o); else pass_cnt++;
        @(posedge clk);
        @(negedge clk); rst_ni = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (valid_o !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", valid_o); else pass_cnt++;
        run_op(3'b000, 32'd3, 32'd4, lat, res, bok, rok);
        total_cnt++; if (res !== 32'h0000_000C) $display("FAIL rst_mul_result: got %h expected 0000000c", res); else pass_cnt++;
        total_cnt++; if (lat !== MUL_LAT) $display("FAIL rst_mul_latency: got %0d expected %0d", lat, MUL_LAT); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_mul_high();
        test_div();
        test_special();
        test_kill();
        test_kill_done();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
